neuron_mac_lanes: RTL and testbench
===================================

# neuron_mac_lanes

Multi-lane serial neuron: y = act(bias + Σ x[i]·w[i]) with round-half-up output scaling, run-time activation select and saturation. It computes LANES products per cycle, so one result takes NUM_INPUTS/LANES accumulate beats. It is the next-generation compute element of the neuron datapath. Results leave through a valid/ready handshake with backpressure, so the block can feed a stalled downstream stage without losing data.

## Interface
- NUM_INPUTS, 8, vector length; must be a multiple of LANES
- LANES, 2, products summed per beat (1..NUM_INPUTS)
- X_W, 8, signed input element width
- W_W, 8, signed weight element width
- B_W, 16, signed bias width; same fractional format as the products
- OUT_W, 16, signed output width
- SHIFT, 4, right shift from product format to output format (0 = none)
- GUARD_BITS, 2, extra accumulator headroom
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- clear  in  1  synchronous abort
- in_valid  in  1  request carries a vector
- in_ready  out  1  block accepts a request (state IDLE)
- act_mode  in  2  0 none, 1 ReLU, 2 leaky ReLU (slope 1/8), 3 treated as 0; sampled on accept
- bias  in  B_W  signed bias
- x_flat  in  NUM_INPUTS*X_W  element i at [i*X_W +: X_W]
- w_flat  in  NUM_INPUTS*W_W  element i at [i*W_W +: W_W]
- out_valid  out  1  result held until accepted
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  signed result
- sat_flag  out  1  out_data was clipped; qualified by out_valid
- busy  out  1  high in states ACC and HOLD

## Operation
- States: IDLE → ACC on in_valid & in_ready. ACC → HOLD after beat BEATS = NUM_INPUTS/LANES. HOLD → IDLE on out_valid & out_ready.
- Accept: latch x_flat, w_flat and act_mode. The accumulator is loaded with bias sign-extended to ACC_W = X_W+W_W+clog2(NUM_INPUTS)+GUARD_BITS. The beat counter is cleared.
- Beat k (0..BEATS-1): acc += Σ over j<LANES of x[k*LANES+j]·w[k*LANES+j]. Products are signed at full width, and the lane sum is exact.
- Finalisation happens on the last beat, combinationally from the final accumulator value:
  - Activation: for mode 1, a negative value becomes 0. For mode 2, a negative value becomes a >>> 3 (arithmetic, floor).
  - Rounding: r = (a + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_W+1 bits. When SHIFT=0, r = a.
  - Saturation: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat_flag=1 if clipped, else 0.
- Inputs are ignored outside IDLE. in_valid in HOLD has no effect.
- clear: next state is IDLE, out_valid←0, sat_flag←0. Any in-progress or held result is discarded. clear has priority over accept and over the output handshake.
- rst mid-operation: immediate return to reset state and the result is lost.

## Timing
- Reset values:
  - state IDLE, out_valid 0, out_data 0, sat_flag 0, busy 0
  - in_ready 1 while reset is asserted, but nothing is accepted until rst is deasserted
- Accept edge E0. Beats occur on edges E1..E_BEATS. out_valid, out_data and sat_flag are registered on E_BEATS. Latency is BEATS cycles (4 with defaults).
- In HOLD, out_data and sat_flag are stable until the handshake edge. out_valid falls on that edge, and in_ready is 1 in the next cycle.
- Minimum initiation interval is BEATS+2 cycles: accept, BEATS beats, then at least one HOLD cycle.
- in_ready and busy are combinational from state only, with no path from in_valid or out_ready.
- LANES = NUM_INPUTS gives BEATS = 1. NUM_INPUTS = 1 is legal.

## Test plan
- Defaults, all x=16, w=16, bias=0, mode 0, out_ready=1 → out_valid 4 cycles after accept, out_data=128, sat_flag 0, then in_ready=1.
- Rounding with only x0, w0 nonzero: x0=1,w0=8 → 1. x0=1,w0=7 → 0. Zero vector with bias=-8 → 0. Zero vector with bias=-9 → -1.
- Activation, zero vector, bias=-1000: mode 0 → -62. mode 1 → 0. mode 2 → -8. mode 3 → -62.
- OUT_W=8 with scenario 1 → out_data=127, sat_flag 1. Negative case x=-128, w=127, bias=0 → out_data=-128, sat_flag 1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 with a new vector → out_valid, out_data and sat_flag stay stable and in_ready=0. After out_ready pulses, the next vector is accepted and produces the correct second result.
- clear asserted on beat 2 → IDLE next cycle, with no out_valid. rst asserted while in HOLD → all outputs return to reset values asynchronously. A fresh request after either completes correctly.

Source files
------------

// File: rtl/neuron_mac_lanes_if.sv
// rtl/neuron_mac_lanes_if.sv - request/result handshake bundle for neuron_mac_lanes
interface neuron_mac_lanes_if #(
  parameter int NUM_INPUTS = 8,
  parameter int X_W        = 8,
  parameter int W_W        = 8,
  parameter int B_W        = 16,
  parameter int OUT_W      = 16
);
  logic                      clear;
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                act_mode;
  logic [B_W-1:0]            bias;
  logic [NUM_INPUTS*X_W-1:0] x_flat;
  logic [NUM_INPUTS*W_W-1:0] w_flat;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_W-1:0]          out_data;
  logic                      sat_flag;
  logic                      busy;

  modport master (
    output clear, in_valid, act_mode, bias, x_flat, w_flat, out_ready,
    input  in_ready, out_valid, out_data, sat_flag, busy
  );

  modport slave (
    input  clear, in_valid, act_mode, bias, x_flat, w_flat, out_ready,
    output in_ready, out_valid, out_data, sat_flag, busy
  );
endinterface

// File: rtl/neuron_mac_lanes.sv
// rtl/neuron_mac_lanes.sv - multi-lane serial MAC neuron with activation, rounding and saturation
module neuron_mac_lanes #(
  parameter int NUM_INPUTS = 8,
  parameter int LANES      = 2,
  parameter int X_W        = 8,
  parameter int W_W        = 8,
  parameter int B_W        = 16,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 4,
  parameter int GUARD_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  neuron_mac_lanes_if.slave  bus
);

  localparam int BEATS = NUM_INPUTS / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int P_W   = X_W + W_W;
  localparam int ACC_W = P_W + $clog2(NUM_INPUTS) + GUARD_BITS;
  localparam int R_W   = ACC_W + 1;
  localparam int SH1   = (SHIFT > 0) ? SHIFT - 1 : 0;

  // Half an output LSB; zero when no scaling is applied so r = a.
  localparam logic signed [R_W-1:0] RND     = (SHIFT > 0) ? R_W'(64'sd1 <<< SH1) : '0;
  localparam logic signed [R_W-1:0] OUT_MAX = R_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [R_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [NUM_INPUTS*X_W-1:0]   r_x;
  logic [NUM_INPUTS*W_W-1:0]   r_w;
  logic [1:0]                  r_mode;
  logic signed [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]            r_beat;
  logic                        r_out_valid;
  logic [OUT_W-1:0]            r_out_data;
  logic                        r_sat;

  logic                        w_last;
  logic signed [ACC_W-1:0]     w_lane_sum;
  logic signed [ACC_W-1:0]     w_acc_next;
  logic signed [ACC_W-1:0]     w_act;
  logic signed [R_W-1:0]       w_act_ext;
  logic signed [R_W-1:0]       w_rnd;
  logic signed [R_W-1:0]       w_round;
  logic [OUT_W-1:0]            w_out;
  logic                        w_sat;

  assign w_last = (r_beat == CNT_W'(BEATS - 1));

  // Exact sum of this beat's LANES products; operands sit in the low slots of the shift registers
  always_comb begin
    logic signed [P_W-1:0] prod;
    w_lane_sum = '0;
    prod       = '0;
    for (int j = 0; j < LANES; j++) begin
      prod       = $signed(r_x[j*X_W +: X_W]) * $signed(r_w[j*W_W +: W_W]);
      w_lane_sum = w_lane_sum + ACC_W'(prod);
    end
  end

  assign w_acc_next = r_acc + w_lane_sum;

  // Activation on the final accumulator value; mode 3 falls through as identity
  always_comb begin
    w_act = w_acc_next;
    if (w_acc_next[ACC_W-1]) begin
      if (r_mode == 2'd1) begin
        w_act = '0;
      end else if (r_mode == 2'd2) begin
        w_act = w_acc_next >>> 3;
      end
    end
  end

  // Round half up with one extra bit so the added half LSB cannot wrap
  assign w_act_ext = R_W'(w_act);
  assign w_rnd     = w_act_ext + RND;
  assign w_round   = w_rnd >>> SHIFT;

  // Clip to the signed output range and flag when clipping happened
  always_comb begin
    w_sat = 1'b0;
    w_out = w_round[OUT_W-1:0];
    if (w_round > OUT_MAX) begin
      w_out = {1'b0, {(OUT_W-1){1'b1}}};
      w_sat = 1'b1;
    end else if (w_round < OUT_MIN) begin
      w_out = {1'b1, {(OUT_W-1){1'b0}}};
      w_sat = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear overrides every other transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_next = ST_ACC;
      ST_ACC:  if (w_last)        w_state_next = ST_HOLD;
      ST_HOLD: if (bus.out_ready) w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
    if (bus.clear) begin
      w_state_next = ST_IDLE;
    end
  end

  // Operand latch, beat accumulation and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x         <= '0;
      r_w         <= '0;
      r_mode      <= '0;
      r_acc       <= '0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else if (bus.clear) begin
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_x    <= bus.x_flat;
            r_w    <= bus.w_flat;
            r_mode <= bus.act_mode;
            r_acc  <= ACC_W'($signed(bus.bias));
            r_beat <= '0;
          end
        end
        ST_ACC: begin
          r_acc  <= w_acc_next;
          r_x    <= r_x >> (LANES * X_W);
          r_w    <= r_w >> (LANES * W_W);
          r_beat <= r_beat + CNT_W'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out;
            r_sat       <= w_sat;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.busy      = (r_state == ST_ACC) || (r_state == ST_HOLD);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sat_flag  = r_sat;

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// tb/tb_neuron_mac_lanes.sv - randomized self-checking bench for neuron_mac_lanes
module tb_neuron_mac_lanes;

  localparam int N    = 8;
  localparam int L    = 2;
  localparam int XW   = 8;
  localparam int WW   = 8;
  localparam int BW   = 16;
  localparam int OW_A = 16;
  localparam int OW_B = 8;
  localparam int SH   = 4;
  localparam int GB   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic            in_valid;
  logic            out_ready;
  logic [1:0]      act_mode;
  logic [BW-1:0]   bias;
  logic [N*XW-1:0] x_flat;
  logic [N*WW-1:0] w_flat;

  always #5 clk = ~clk;

  neuron_mac_lanes_if #(.NUM_INPUTS(N), .X_W(XW), .W_W(WW), .B_W(BW), .OUT_W(OW_A)) bus_a ();
  neuron_mac_lanes_if #(.NUM_INPUTS(N), .X_W(XW), .W_W(WW), .B_W(BW), .OUT_W(OW_B)) bus_b ();

  assign bus_a.clear     = clear;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.act_mode  = act_mode;
  assign bus_a.bias      = bias;
  assign bus_a.x_flat    = x_flat;
  assign bus_a.w_flat    = w_flat;
  assign bus_a.out_ready = out_ready;
  assign bus_b.clear     = clear;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.act_mode  = act_mode;
  assign bus_b.bias      = bias;
  assign bus_b.x_flat    = x_flat;
  assign bus_b.w_flat    = w_flat;
  assign bus_b.out_ready = out_ready;

  neuron_mac_lanes #(.NUM_INPUTS(N), .LANES(L), .X_W(XW), .W_W(WW), .B_W(BW),
                     .OUT_W(OW_A), .SHIFT(SH), .GUARD_BITS(GB))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  neuron_mac_lanes #(.NUM_INPUTS(N), .LANES(L), .X_W(XW), .W_W(WW), .B_W(BW),
                     .OUT_W(OW_B), .SHIFT(SH), .GUARD_BITS(GB))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int     n_cmp = 0;
  int     n_err = 0;
  int     vx[N];
  int     vw[N];
  int     vbias;
  int     vmode;
  longint last_a, last_sa, last_b, last_sb;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer dot product, then activation, half-up rounding and clipping
  function automatic void model(input int ow, output longint y, output longint s);
    longint a;
    longint mx;
    longint mn;
    a = vbias;
    for (int i = 0; i < N; i++) a += longint'(vx[i]) * longint'(vw[i]);
    if (a < 0 && vmode == 1) a = 0;
    else if (a < 0 && vmode == 2) a = a >>> 3;
    if (SH > 0) a = (a + (longint'(1) <<< (SH - 1))) >>> SH;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    s = 0;
    y = a;
    if (a > mx) begin y = mx; s = 1; end
    else if (a < mn) begin y = mn; s = 1; end
  endfunction

  task automatic fill(input int xv, input int wv, input int b, input int m);
    for (int i = 0; i < N; i++) begin vx[i] = xv; vw[i] = wv; end
    vbias = b;
    vmode = m;
  endtask

  task automatic rand_vec();
    for (int i = 0; i < N; i++) begin
      vx[i] = int'($urandom_range(0, 255)) - 128;
      vw[i] = int'($urandom_range(0, 255)) - 128;
    end
    vbias = int'($urandom_range(0, 65535)) - 32768;
    vmode = int'($urandom_range(0, 3));
  endtask

  task automatic drive_vec();
    for (int i = 0; i < N; i++) begin
      x_flat[i*XW +: XW] = XW'(vx[i]);
      w_flat[i*WW +: WW] = WW'(vw[i]);
    end
    bias     = BW'(vbias);
    act_mode = 2'(vmode);
    in_valid = 1'b1;
  endtask

  // Called just after a falling edge; returns just after the falling edge following the accept
  task automatic accept();
    drive_vec();
    check("in_ready_at_accept", bus_a.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x_flat   = {$urandom, $urandom};
    w_flat   = {$urandom, $urandom};
    bias     = BW'($urandom);
    act_mode = 2'($urandom);
  endtask

  task automatic collect(input int hold, input bit preload);
    int     lat;
    longint ea, sa, eb, sb;
    model(OW_A, ea, sa);
    model(OW_B, eb, sb);
    lat = 0;
    while (!bus_a.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    check("busy_in_hold", bus_a.busy, 1);
    check("valid_b", bus_b.out_valid, 1);
    check("data_a", $signed(bus_a.out_data), ea);
    check("sat_a", bus_a.sat_flag, sa);
    check("data_b", $signed(bus_b.out_data), eb);
    check("sat_b", bus_b.sat_flag, sb);
    last_a  = $signed(bus_a.out_data);
    last_sa = bus_a.sat_flag;
    last_b  = $signed(bus_b.out_data);
    last_sb = bus_b.sat_flag;
    if (preload) begin
      rand_vec();
      drive_vec();
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", bus_a.out_valid, 1);
      check("hold_data_a", $signed(bus_a.out_data), ea);
      check("hold_sat_b", bus_b.sat_flag, sb);
      check("hold_in_ready", bus_a.in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_hs", bus_a.out_valid, 0);
    check("in_ready_after_hs", bus_a.in_ready, 1);
  endtask

  int tx0[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
  int tw0[8] = '{8, 7, 0, 0, 0, 0, 0, 0};
  int tbs[8] = '{0, 0, -8, -9, -1000, -1000, -1000, -1000};
  int tmd[8] = '{0, 0, 0, 0, 0, 1, 2, 3};
  int tex[8] = '{1, 0, 0, -1, -62, 0, -8, -62};

  initial begin
    int quiet;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    act_mode  = '0;
    bias      = '0;
    x_flat    = '0;
    w_flat    = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus_a.in_ready, 1);
    check("rst_busy", bus_a.busy, 0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_data", bus_a.out_data, 0);
    check("rst_sat", bus_a.sat_flag, 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_busy", bus_a.busy, 0);

    // Scenario 1: all 16s, bias 0, immediate handshake
    fill(16, 16, 0, 0);
    accept();
    collect(0, 1'b0);
    check("s1_data_a", last_a, 128);
    check("s1_sat_a", last_sa, 0);
    check("s1_data_b", last_b, 127);
    check("s1_sat_b", last_sb, 1);

    // Rounding and activation corners
    for (int r = 0; r < 8; r++) begin
      fill(0, 0, tbs[r], tmd[r]);
      vx[0] = tx0[r];
      vw[0] = tw0[r];
      accept();
      collect(int'($urandom_range(0, 2)), 1'b0);
      check($sformatf("corner%0d", r), last_a, tex[r]);
    end

    // Negative saturation on the narrow output
    fill(-128, 127, 0, 0);
    accept();
    collect(1, 1'b0);
    check("neg_sat_b", last_b, -128);
    check("neg_sat_flag_b", last_sb, 1);

    // Backpressure with a new request waiting during HOLD
    rand_vec();
    accept();
    collect(5, 1'b1);
    accept();
    collect(0, 1'b0);

    // clear during accumulation discards the result
    fill(16, 16, 0, 0);
    accept();
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check("clr_in_ready", bus_a.in_ready, 1);
    check("clr_busy", bus_a.busy, 0);
    check("clr_valid", bus_a.out_valid, 0);
    quiet = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      quiet += int'(bus_a.out_valid);
    end
    check("clr_no_valid_later", quiet, 0);
    rand_vec();
    accept();
    collect(1, 1'b0);

    // Asynchronous reset while a result is held
    fill(16, 16, 0, 0);
    accept();
    quiet = 0;
    while (!bus_a.out_valid && quiet < 20) begin
      @(posedge clk);
      @(negedge clk);
      quiet++;
    end
    check("rst_hold_reached", bus_a.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", bus_a.out_valid, 0);
    check("arst_data", bus_a.out_data, 0);
    check("arst_sat_b", bus_b.sat_flag, 0);
    check("arst_busy", bus_a.busy, 0);
    check("arst_in_ready", bus_a.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rand_vec();
    accept();
    collect(0, 1'b0);

    // Random traffic with random output stalls
    for (int t = 0; t < 40; t++) begin
      rand_vec();
      accept();
      collect(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
